// File: rtl/decoder_rr_scheduler.sv
// Round-robin owner selection for the shared 3-to-8 decoder datapath.
// One owner at a time, bounded dwell, and a one-cycle settle gap between owners.
module decoder_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 100,
  localparam int unsigned CW = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] da,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    da_q, da_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       hit;
  logic [2:0] idx;
  logic [2:0] cand;
  logic       rel_evt;
  logic       at_lim;
  logic       release_now;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    hit  = 1'b0;
    idx  = 3'd0;
    cand = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
  end

  assign rel_evt     = done | ~req[da_q];
  assign at_lim      = (cnt_q == CW'(MAX_HOLD - 1));
  assign release_now = rel_evt | at_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_GRANT;
      S_GRANT: if (release_now) state_d = S_GAP;
      S_GAP:   state_d = hit ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    da_d      = da_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (release_now) begin
          gnt_d     = 8'd0;
          busy_d    = 1'b0;
          ptr_d     = da_q + 3'd1;
          cnt_d     = '0;
          // A coincident done/req-drop counts as a normal release.
          timeout_d = at_lim & ~rel_evt;
        end
      end
      default: begin
        gnt_d  = 8'd0;
        busy_d = 1'b0;
        if (hit) begin
          da_d   = idx;
          gnt_d  = 8'b1 << idx;
          busy_d = 1'b1;
          cnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_q      <= 3'd0;
      gnt_q     <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
    end else begin
      da_q      <= da_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign da      = da_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Bench for decoder_rr_scheduler: vector table, corner sequences, random vs reference model.
module tb_decoder_rr_scheduler;

  localparam int unsigned MH = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [2:0] da;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  decoder_rr_scheduler #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .da(da), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] da;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vt[9];

  // Reference: owner = -1 means nobody holds the decoder (idle or gap look the same
  // from outside; the gap arises because a release edge never also arbitrates).
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [2:0] m_da;
  logic       m_to;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_da = 3'd0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || m_held == int'(MH)) begin
        m_to    = !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end else if (r != 8'd0) begin
      for (int k = 7; k >= 0; k--)
        if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      m_da   = 3'(m_owner);
      m_held = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'd0; done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vt[1] = '{8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0};
    vt[2] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vt[3] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vt[4] = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
    vt[5] = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
    vt[6] = '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vt[7] = '{8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[8] = '{8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};

    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_da", 32'(da), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);

    // Single request, done, gap re-grant, req drop, wrap-and-skip from ptr=5.
    for (int v = 0; v < 9; v++) begin
      req = vt[v].req; done = vt[v].done;
      step();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vt[v].gnt));
      chk($sformatf("vec%0d_da", v), 32'(da), 32'(vt[v].da));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].busy));
      chk($sformatf("vec%0d_to", v), 32'(timeout), 32'(vt[v].to));
    end

    // Rotation with all requesters active.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rot_da", 32'(da), 32'(i % 8));
      chk("rot_gnt", 32'(gnt), 32'(8'h01 << (i % 8)));
      done = 1'b1;
      step();
      chk("rot_gap", 32'(gnt), 32'h0);
      done = 1'b0;
    end

    // Forced release after MH cycles.
    do_reset();
    req = 8'h01;
    for (int k = 0; k < int'(MH); k++) begin
      step();
      chk("to_hold_gnt", 32'(gnt), 32'h01);
      chk("to_hold_pulse", 32'(timeout), 32'h0);
    end
    step();
    chk("to_rel_gnt", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    step();
    chk("to_regrant", 32'(gnt), 32'h01);
    chk("to_pulse_end", 32'(timeout), 32'h0);

    // done in the last allowed cycle: release without timeout.
    do_reset();
    req = 8'h01;
    repeat (MH) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("sim_done_gnt", 32'(gnt), 32'h0);
    chk("sim_done_to", 32'(timeout), 32'h0);

    // req drop + done together: ptr advances by one.
    do_reset();
    req = 8'h0E;
    step();
    chk("sim_da1", 32'(da), 32'h1);
    req = 8'h0C; done = 1'b1;
    step();
    done = 1'b0;
    chk("sim_rel", 32'(gnt), 32'h0);
    step();
    chk("sim_next_da", 32'(da), 32'h2);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 8'h08;
    step();
    chk("ar_pre", 32'(gnt), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_da", 32'(da), 32'h0);
    req = 8'h0C;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_regrant_da", 32'(da), 32'h2);
    chk("ar_regrant_gnt", 32'(gnt), 32'h04);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      model_edge(req, done);
      step();
      chk("rnd", {gnt, 5'd0, da, 7'd0, busy, 7'd0, timeout},
          {(m_owner >= 0) ? (8'h01 << m_owner) : 8'h00, 5'd0, m_da,
           7'd0, (m_owner >= 0), 7'd0, m_to});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_rr_scheduler.md
Name: decoder_rr_scheduler

Overview:
- Round-robin scheduler that shares the registered 3-to-8 decoder datapath between 8 requesters.
- Picks one requester and drives the decoder select `da` with its index.
- Presents a matching one-hot grant and holds it for a bounded dwell time.
- Inserts a one-cycle gap between grants so the decoder output settles before the next owner.

Parameters:
- MAX_HOLD, 100, maximum cycles a grant may be held before forced release; legal range 1..65535.
- CW, $clog2(MAX_HOLD+1), dwell counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the decoder.
- done  input  1  release pulse from the current owner.
- da  output  3  decoder select index, registered.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly released at MAX_HOLD.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n); all state clears immediately on rst_n low, independent of clk.
- Reset values: da=0, gnt=0, busy=0, timeout=0, state=IDLE, ptr=0, cnt=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - gnt=0.
  - If req != 0, select idx = first set bit searching ptr, ptr+1, ... mod 8.
  - Next edge: da<=idx, gnt<=1<<idx, busy<=1, cnt<=0, state<=GRANT.
  - Latency from req seen to gnt high is 1 cycle.
- GRANT:
  - cnt increments each cycle.
  - Release when any one of:
    - done=1, or
    - req[da]=0, or
    - cnt==MAX_HOLD-1.
  - On release: gnt<=0, busy<=0, ptr<=da+1 (mod 8, wraps 7->0), state<=GAP.
  - Timeout pulse: timeout<=1 for exactly one cycle only when release is due solely to cnt==MAX_HOLD-1.
  - Result: a grant never exceeds MAX_HOLD cycles.
- Simultaneous release events: done or req drop in the same cycle as the count limit -> normal release, no timeout pulse.
- GAP:
  - Exactly 1 cycle: gnt=0, da holds the previous index.
  - Then arbitrates like IDLE using the updated ptr:
    - req != 0: enter GRANT on the next edge (grant-to-grant spacing is 1 idle cycle).
    - otherwise: go to IDLE.
- Fairness: with all 8 requests held high, grants rotate 0,1,...,7,0; no requester waits more than 7 grant periods.
- Requests changing during GRANT do not affect the current owner except req[da] dropping.
- done is ignored in IDLE and GAP.
- Reset asserted mid-grant: gnt clears asynchronously; after release, arbitration restarts from ptr=0.
- Invariants:
  - gnt is always zero or one-hot.
  - When gnt != 0, gnt == 1<<da.

Test Plan:
- Reset then single request: rst_n low 3 cycles, release; req=8'h10 -> one cycle later gnt=8'h10, da=4, busy=1; done pulse -> next cycle gnt=0, one GAP cycle, then gnt=8'h10 again if req still high.
- Rotation: req=8'hFF held, done pulsed 1 cycle after each grant -> da sequence 0,1,2,3,4,5,6,7,0, each grant separated by one gnt=0 cycle; gnt is always 1<<da.
- Timeout: MAX_HOLD=5, req=8'h01 held, done never asserted -> gnt=8'h01 for exactly 5 cycles, timeout high 1 cycle at release, re-grant after the GAP.
- Simultaneous events: MAX_HOLD=5; done asserted in the 5th grant cycle -> release with timeout=0; req drop and done in the same cycle -> single release, ptr advances by one only.
- Pointer wrap and skip: grant on index 7 released, req=8'h05 -> next grant da=0, then da=2; index 1 never granted.
- Async reset mid-grant: while gnt=8'h08, drive rst_n low between clock edges -> gnt=0, busy=0, da=0 immediately; after release with req=8'h0C -> grant goes to da=2 (ptr restarted at 0).
